// File: rtl/led_chain_master.sv
// Serialises one byte per chained LED slave onto serial_out, with one shift_clk_en strobe per bit, plus pad and latch bits.
// Latency: busy and the first bit appear at the accepting edge; done pulses 9*N_SLAVES*2*HALF_PERIOD cycles later.
// Backpressure: start is taken only while idle; start and frame changes are ignored while busy.
module led_chain_master #(
    parameter int N_SLAVES    = 4,
    parameter int HALF_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*N_SLAVES-1:0] frame,
    output logic                  busy,
    output logic                  done,
    output logic                  shift_clk_en,
    output logic                  serial_out
);
    localparam int NBITS = 9 * N_SLAVES;
    localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int PW    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(HALF_PERIOD - 1);

    logic [1:0]       state;
    logic [NBITS-1:0] stream;
    logic [NBITS-1:0] stream_init;
    logic [BW-1:0]    bit_cnt;
    logic [PW-1:0]    phase;

    // Reorder the frame into transmit order: farthest slave's byte first,
    // each byte MSB first, followed by a zero (pad, or latch after byte 0).
    always_comb begin
        stream_init = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            for (int i = 0; i < 8; i++) begin
                stream_init[9*j+i] = frame[8*(N_SLAVES-1-j)+7-i];
            end
        end
    end

    // Strobe FSM: LOW and HIGH phases of HALF_PERIOD cycles each; the next
    // bit is presented on the strobe's falling edge so it is stable across
    // the following low phase and the rising edge the slaves act on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            stream       <= '0;
            bit_cnt      <= '0;
            phase        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            shift_clk_en <= 1'b0;
            serial_out   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LOW;
                        stream     <= stream_init;
                        bit_cnt    <= '0;
                        phase      <= '0;
                        serial_out <= stream_init[0];
                        busy       <= 1'b1;
                    end
                end
                S_LOW: begin
                    if (phase == LAST_PH) begin
                        phase        <= '0;
                        state        <= S_HIGH;
                        shift_clk_en <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (phase == LAST_PH) begin
                        phase        <= '0;
                        shift_clk_en <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state      <= S_IDLE;
                            serial_out <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            state      <= S_LOW;
                            bit_cnt    <= bit_cnt + 1'b1;
                            // stream[0] always holds the bit currently on the wire
                            stream     <= {1'b0, stream[NBITS-1:1]};
                            serial_out <= stream[1];
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/led_chain_master.md
# led_chain_master

Drives a daisy chain of 8-bit LED shift slaves from one master port. It accepts a frame of one byte per slave and serialises it onto `serial_out`, with a strobe on `shift_clk_en` for each bit. When the frame completes, every slave's `leds` shows its own byte. It sits between the control logic and the first slave of the chain.

## Interface
- `N_SLAVES`, default 4: number of chained slaves; must be ≥1.
- `HALF_PERIOD`, default 4: clk cycles per strobe phase (low, then high); must be ≥1.

- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request to send `frame`; sampled only while idle.
- `frame`  in  8*N_SLAVES  byte k (`frame[8k+7:8k]`) is destined for slave k. Slave 0 is nearest the master.
- `busy`  out  1  high from the cycle after an accepted `start` until the frame ends.
- `done`  out  1  one-cycle pulse after the final strobe.
- `shift_clk_en`  out  1  shift strobe to all slaves; slaves act on its rising edge.
- `serial_out`  out  1  data to the `serial_in` of slave 0.

## Operation
- Slave model:
  - On each strobe rising edge, a slave shifts `serial_in` into `sr[0]`.
  - The slave's registered `serial_out` takes the old `sr[7]`.
  - `leds` takes the pre-shift `sr`.
  - The chain therefore has 9 positions per slave: `sr[0..7]` plus the output register.
  - `leds` lags `sr` by one strobe.
- Bit stream per frame: 9*N_SLAVES bits, sent in this order:
  - For k = N_SLAVES-1 down to 0: byte k, MSB first.
  - After each byte except byte 0: one pad bit = 0.
  - Finally: one latch bit = 0. The extra strobe copies each `sr` into `leds`.
- States:
  - IDLE: `shift_clk_en`=0, `serial_out`=0, `busy`=0.
  - LOW: `shift_clk_en`=0 for HALF_PERIOD cycles.
  - HIGH: `shift_clk_en`=1 for HALF_PERIOD cycles.
- Transitions:
  - IDLE to LOW: on `start`=1.
    - The frame is captured into a 9N-bit stream register.
    - The bit counter is cleared.
    - `serial_out` takes stream bit 0 at the same edge.
  - LOW to HIGH: after HALF_PERIOD cycles.
  - HIGH, when the bit counter < 9N-1: counter increments, `serial_out` takes the next bit, go to LOW.
  - HIGH, when the bit counter = 9N-1: go to IDLE, `serial_out` takes 0, `done` takes 1 for one cycle.
- `start` while busy: ignored. `frame` changes while busy: ignored, because the frame is captured at start.
- Bit counter width: clog2(9*N_SLAVES). Phase counter width: clog2(HALF_PERIOD), minimum 1 bit.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - State becomes IDLE.
  - `shift_clk_en`, `serial_out`, `busy` and `done` all become 0.
  - Stream register and both counters are cleared.
  - Reset mid-frame aborts the frame at that edge, with no `done`. Slave contents are then undefined until the next full frame overwrites them.
- Accepted `start` at edge t0:
  - From t0: `busy`=1 and `serial_out`=bit 0.
  - Strobe rises at t0+H and falls at t0+2H, with H = HALF_PERIOD.
- `serial_out` changes only on the strobe's falling edge, and at frame start. It is stable for H cycles before each rising edge and through each high phase.
- Frame length: 9*N_SLAVES*2H cycles from t0 to the edge where `busy`=0 and `done`=1.
- `start` high in the `done` cycle is accepted, giving back-to-back frames. This leaves one IDLE cycle with the strobe low between frames.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → all outputs 0 and no strobe. Assert reset mid-frame → strobe is 0 at the next edge and `done` never pulses.
- Basic frame, N_SLAVES=2, HALF_PERIOD=2, `frame`=16'hA53C:
  - `serial_out` per strobe: 1,0,1,0,0,1,0,1, 0, 0,0,1,1,1,1,0,0, 0.
  - 18 strobes; `done` at t0+72.
  - With two slave models chained: slave1 `leds`=8'hA5, slave0 `leds`=8'h3C.
- HALF_PERIOD=1, N_SLAVES=1, `frame`=8'h81:
  - Strobe toggles every cycle.
  - Stream is 1,0,0,0,0,0,0,1, 0.
  - Slave `leds`=8'h81 after 18 cycles.
- `start` pulsed and `frame` changed while busy → no restart, and the original frame is delivered unchanged.
- Back-to-back: 8'hFF then 8'h00, with `start` held through `done` → second frame begins the cycle after `done`, and final `leds`=8'h00.
